// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds, sticky error flags and flush.
// Latency: registered read gives data 1 cycle after the accepting edge; show-ahead presents the head word combinationally.
// Backpressure: writes are rejected when full unless a read frees a slot that cycle; rejected requests set sticky flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  // Threshold legality is a build-time property of the instance.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  r_accept, w_accept;

  // Flags come from the registered count only, never from the request inputs.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop on a full FIFO frees the slot the concurrent write lands in; no empty bypass.
  assign r_accept = r_enable && !empty;
  assign w_accept = w_enable && (!full || r_accept);

  // Next-state for pointers, occupancy and sticky flags; flush zeroes them all.
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (w_accept) w_ptr_d = w_ptr_q + PTR_ONE;
    if (r_accept) r_ptr_d = r_ptr_q + PTR_ONE;
    if (w_accept && !r_accept) begin
      count_d = count_q + CNT_ONE;
    end else if (r_accept && !w_accept) begin
      count_d = count_q - CNT_ONE;
    end
    if (w_enable && !w_accept) overflow_d = 1'b1;
    if (r_enable && empty) underflow_d = 1'b1;
    if (clear) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never reset; reset/flush only discard it by moving the pointers.
  always_ff @(posedge clk) begin
    if (reset_n && !clear && w_accept) mem_q[w_ptr_q] <= w_data;
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign r_data  = mem_q[r_ptr_q];
    assign r_valid = !empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // Registered read port: data holds between pops, valid pulses once per pop.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (clear) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= r_accept;
        if (r_accept) r_data_q <= mem_q[r_ptr_q];
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one show-ahead instance share identical stimulus.
// Latency: outputs are checked on the falling edge after every rising edge against a queue model.
// Backpressure: the model decides acceptance independently and predicts flags, count and read data.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n, clr, we, re;
  logic [7:0] wd;

  logic [7:0] r_data0, r_data1;
  logic       r_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic       r_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: words pushed on accepted writes, popped on accepted reads.
  logic [7:0] mq[$];
  logic [7:0] m_rd;
  bit         m_rv, m_ov, m_un;

  sync_fifo_param #(.SHOW_AHEAD(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .clear(clr), .w_enable(we), .w_data(wd), .r_enable(re),
    .r_data(r_data0), .r_valid(r_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.SHOW_AHEAD(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .clear(clr), .w_enable(we), .w_data(wd), .r_enable(re),
    .r_data(r_data1), .r_valid(r_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_flags(input string p, input logic [4:0] c, input logic f, input logic e,
                           input logic af, input logic ae, input logic ov, input logic un);
    int n;
    n = mq.size();
    chk({p, ".count"}, 32'(c), n);
    chk({p, ".full"}, 32'(f), 32'(n == 16));
    chk({p, ".empty"}, 32'(e), 32'(n == 0));
    chk({p, ".almost_full"}, 32'(af), 32'(n >= 12));
    chk({p, ".almost_empty"}, 32'(ae), 32'(n <= 2));
    chk({p, ".overflow"}, 32'(ov), 32'(m_ov));
    chk({p, ".underflow"}, 32'(un), 32'(m_un));
  endtask

  task automatic check_all();
    chk_flags("sa0", count0, full0, empty0, af0, ae0, ovf0, unf0);
    chk_flags("sa1", count1, full1, empty1, af1, ae1, ovf1, unf1);
    chk("sa0.r_valid", 32'(r_valid0), 32'(m_rv));
    chk("sa0.r_data", 32'(r_data0), 32'(m_rd));
    chk("sa1.r_valid", 32'(r_valid1), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("sa1.r_data", 32'(r_data1), 32'(mq[0]));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check on the next falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    bit r_acc, w_acc;
    we = w; wd = d; re = r; clr = c; rst_n = !rs;
    @(posedge clk);
    if (rs) begin
      mq.delete(); m_ov = 0; m_un = 0; m_rv = 0; m_rd = 8'h00;
    end else if (c) begin
      mq.delete(); m_ov = 0; m_un = 0; m_rv = 0;
    end else begin
      r_acc = r && (mq.size() != 0);
      w_acc = w && ((mq.size() < 16) || r_acc);
      if (w && !w_acc) m_ov = 1;
      if (r && mq.size() == 0) m_un = 1;
      m_rv = 0;
      if (r_acc) begin
        m_rd = mq.pop_front();
        m_rv = 1;
      end
      if (w_acc) mq.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; wd = 8'h00;
    m_rd = 8'h00; m_rv = 0; m_ov = 0; m_un = 0;
    @(negedge clk);

    // Reset state.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Fill to full, then a rejected 17th write.
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Drain in order, then read while empty.
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Full with simultaneous read and write, across the pointer wrap.
    step(0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Empty with simultaneous read and write: write only, underflow sets.
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h55, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Single word into an empty FIFO, then pop it.
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Flush with a concurrent write, after provoking an overflow-free underflow.
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Reset in the middle of a write burst; registered read data returns to zero.
    for (int i = 0; i < 5; i++) step(1, 8'(8'hD0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hEF, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
